// File: rtl/conv_window_scheduler.sv
// conv_window_scheduler
//   Streams an IMG_W x IMG_H image out of a synchronous ROM, in row-major
//   order, to a line buffer. Each pixel carries tags that mark the end of a
//   row and the end of the frame. A further tag marks when the pixel completes
//   a K_R x K_S window, and gives that window's output-map coordinates.
//
// Ports
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   start           one-cycle pulse; launches a frame when idle
//   abort           synchronous cancel of the frame in progress
//   rom_en/rom_addr ROM read request; data returns on rom_data one cycle later
//   rom_data        ROM read data
//   pix_valid/pix_ready/pix_data/pix_eol/pix_last
//                   pixel stream toward the line buffer
//   win_valid/out_row/out_col
//                   window-complete tag and output coordinates
//   busy, done      frame in progress / one-cycle end-of-frame pulse
//   state_dbg       current FSM state (IDLE=0, FETCH=1, DRAIN=2, DONE=3)
//
// Handshake: a pixel transfers on a rising edge where pix_valid && pix_ready.
// While pix_valid is high and pix_ready is low, every pix_* / window output
// stays unchanged. pix_valid never drops until its transfer happens, except
// on abort or reset.
module conv_window_scheduler #(
  parameter int IMG_W     = 28,
  parameter int IMG_H     = 28,
  parameter int K_R       = 5,
  parameter int K_S       = 5,
  parameter int INT_WIDTH = 8,
  parameter int ADDR_W    = $clog2(IMG_W*IMG_H)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  output logic                 rom_en,
  output logic [ADDR_W-1:0]    rom_addr,
  input  logic [INT_WIDTH-1:0] rom_data,
  output logic                 pix_valid,
  input  logic                 pix_ready,
  output logic [INT_WIDTH-1:0] pix_data,
  output logic                 pix_eol,
  output logic                 pix_last,
  output logic                 win_valid,
  output logic [7:0]           out_row,
  output logic [7:0]           out_col,
  output logic                 busy,
  output logic                 done,
  output logic [1:0]           state_dbg
);

  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;

  typedef struct packed {
    logic       eol;
    logic       last;
    logic       win;
    logic [7:0] orow;
    logic [7:0] ocol;
  } tag_t;

  typedef struct packed {
    logic [INT_WIDTH-1:0] data;
    tag_t                 tag;
  } entry_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_W*IMG_H-1);
  localparam logic [15:0]       LAST_COL  = 16'(IMG_W-1);
  localparam logic [15:0]       LAST_ROW  = 16'(IMG_H-1);
  localparam logic [15:0]       WIN_R     = 16'(K_R-1);
  localparam logic [15:0]       WIN_C     = 16'(K_S-1);

  state_t            state_q, state_n;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       col_q, row_q;
  logic              inflight_q;   // a read was issued last cycle; data is on rom_data now
  tag_t              tag_q;        // tags of the in-flight read
  entry_t            e0_q, e1_q;   // two-entry output FIFO, e0 is the head
  logic [1:0]        cnt_q;

  logic       pop, push, flush, last_issue;
  logic [1:0] occ_after;
  tag_t       issue_tag;
  entry_t     e0_n, e1_n;
  logic [1:0] cnt_n;

  // Tags come from the row/col counters at the moment the read is issued.
  always_comb begin
    issue_tag      = '0;
    issue_tag.eol  = (col_q == LAST_COL);
    issue_tag.last = (col_q == LAST_COL) && (row_q == LAST_ROW);
    issue_tag.win  = (row_q >= WIN_R) && (col_q >= WIN_C);
    if (issue_tag.win) begin
      issue_tag.orow = 8'(row_q - WIN_R);
      issue_tag.ocol = 8'(col_q - WIN_C);
    end
  end

  assign pix_valid = (cnt_q != 2'd0);
  assign pop       = pix_valid && pix_ready;
  assign push      = inflight_q;
  assign flush     = abort && (state_q != IDLE);
  // Occupancy once this cycle's transfer (if any) has left the FIFO. Counting
  // the outgoing pixel as freed is what allows one pixel per cycle, while the
  // sum of reads in flight and stored pixels still never exceeds two.
  assign occ_after = cnt_q - {1'b0, pop};

  assign rom_en     = (state_q == FETCH) && (({1'b0, inflight_q} + occ_after) < 2'd2);
  assign rom_addr   = addr_q;
  assign last_issue = rom_en && (addr_q == LAST_ADDR);

  assign pix_data  = pix_valid ? e0_q.data     : '0;
  assign pix_eol   = pix_valid ? e0_q.tag.eol  : 1'b0;
  assign pix_last  = pix_valid ? e0_q.tag.last : 1'b0;
  assign win_valid = pix_valid ? e0_q.tag.win  : 1'b0;
  assign out_row   = pix_valid ? e0_q.tag.orow : 8'd0;
  assign out_col   = pix_valid ? e0_q.tag.ocol : 8'd0;

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign state_dbg = state_q;

  // FIFO next state: shift on pop, then write the returning pixel into the
  // first free slot.
  always_comb begin
    e0_n  = e0_q;
    e1_n  = e1_q;
    cnt_n = occ_after + {1'b0, push};
    if (pop) e0_n = e1_q;
    if (push) begin
      if (occ_after == 2'd0) e0_n = '{data: rom_data, tag: tag_q};
      else                   e1_n = '{data: rom_data, tag: tag_q};
    end
  end

  always_comb begin
    state_n = state_q;
    case (state_q)
      IDLE:    if (start && !abort) state_n = FETCH;
      FETCH:   if (last_issue) state_n = DRAIN;
      DRAIN:   if (pop && e0_q.tag.last) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (flush) state_n = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      col_q      <= '0;
      row_q      <= '0;
      inflight_q <= 1'b0;
      tag_q      <= '0;
      e0_q       <= '0;
      e1_q       <= '0;
      cnt_q      <= '0;
    end else begin
      state_q <= state_n;
      if (flush) begin
        addr_q     <= '0;
        col_q      <= '0;
        row_q      <= '0;
        inflight_q <= 1'b0;
        cnt_q      <= '0;
      end else begin
        inflight_q <= rom_en;
        e0_q       <= e0_n;
        e1_q       <= e1_n;
        cnt_q      <= cnt_n;
        if (rom_en) begin
          tag_q <= issue_tag;
          // Counters return to zero after the final read, so rom_addr reads 0
          // for the remainder of the frame.
          if (last_issue) begin
            addr_q <= '0;
            col_q  <= '0;
            row_q  <= '0;
          end else begin
            addr_q <= addr_q + 1'b1;
            if (col_q == LAST_COL) begin
              col_q <= '0;
              row_q <= row_q + 16'd1;
            end else begin
              col_q <= col_q + 16'd1;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_conv_window_scheduler.sv
module tb_conv_window_scheduler;

  localparam int IMG_W = 28;
  localparam int IMG_H = 28;
  localparam int K_R   = 5;
  localparam int K_S   = 5;
  localparam int W     = 8;
  localparam int N     = IMG_W*IMG_H;
  localparam int AW    = $clog2(N);
  localparam int N_WIN = (IMG_H-K_R+1)*(IMG_W-K_S+1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          rom_en;
  logic [AW-1:0] rom_addr;
  logic [W-1:0]  rom_data = '0;
  logic          pix_valid;
  logic          pix_ready = 1'b1;
  logic [W-1:0]  pix_data;
  logic          pix_eol, pix_last, win_valid, busy, done;
  logic [7:0]    out_row, out_col;
  logic [1:0]    state_dbg;

  conv_window_scheduler #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .K_R(K_R), .K_S(K_S), .INT_WIDTH(W), .ADDR_W(AW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .pix_eol(pix_eol), .pix_last(pix_last), .win_valid(win_valid),
    .out_row(out_row), .out_col(out_col), .busy(busy), .done(done),
    .state_dbg(state_dbg)
  );

  // ---------------- clock / reset / cycle counter ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Synchronous ROM: data for an address requested in cycle t appears in t+1.
  logic [W-1:0] rom [0:N-1];
  always @(posedge clk) if (rom_en) rom_data <= rom[rom_addr];

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  int n_iss, n_pop, win_cnt, eol_cnt, last_cnt, done_cnt, done_cyc;
  int first_rom_cyc, first_valid_cyc, last_hs_cyc, first_win_idx, last_win_idx;
  int max_out, stall_obs;
  logic         prev_stall;
  logic [W-1:0] prev_data;
  int rdy_mode = 0;   // 0: always ready, 1: one 10-cycle stall at pixel 50, 2: random
  int stall_left = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic clear_stats();
    n_iss = 0; n_pop = 0; win_cnt = 0; eol_cnt = 0; last_cnt = 0;
    done_cnt = 0; done_cyc = -1; first_rom_cyc = -1; first_valid_cyc = -1;
    last_hs_cyc = -1; first_win_idx = -1; last_win_idx = -1;
    max_out = 0; stall_obs = 0; prev_stall = 1'b0; prev_data = '0;
    exp_q.delete();
  endtask

  // New random image; the expected stream is simply the image in address order.
  task automatic load_image();
    for (int i = 0; i < N; i++) rom[i] = W'($urandom_range(0, (1<<W)-1));
    exp_q.delete();
    for (int i = 0; i < N; i++) exp_q.push_back(rom[i]);
  endtask

  task automatic check_all_zero(input string pfx);
    check_eq({pfx, "_rom_en"},    32'(rom_en),    0);
    check_eq({pfx, "_rom_addr"},  32'(rom_addr),  0);
    check_eq({pfx, "_pix_valid"}, 32'(pix_valid), 0);
    check_eq({pfx, "_pix_data"},  32'(pix_data),  0);
    check_eq({pfx, "_pix_eol"},   32'(pix_eol),   0);
    check_eq({pfx, "_pix_last"},  32'(pix_last),  0);
    check_eq({pfx, "_win_valid"}, 32'(win_valid), 0);
    check_eq({pfx, "_out_row"},   32'(out_row),   0);
    check_eq({pfx, "_out_col"},   32'(out_col),   0);
    check_eq({pfx, "_busy"},      32'(busy),      0);
    check_eq({pfx, "_done"},      32'(done),      0);
    check_eq({pfx, "_state"},     32'(state_dbg), 0);
  endtask

  // ---------------- pix_ready driver ----------------
  initial forever begin
    @(posedge clk);
    #1;
    case (rdy_mode)
      1: begin
        if (n_pop == 50 && stall_left > 0) begin
          pix_ready = 1'b0;
          stall_left--;
        end else pix_ready = 1'b1;
      end
      2:       pix_ready = 1'($urandom_range(0, 1));
      default: pix_ready = 1'b1;
    endcase
  end

  // ---------------- monitor (samples mid-cycle) ----------------
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      logic hs;
      int   outst, row, col;
      logic win;
      hs = pix_valid && pix_ready;
      if (prev_stall) begin
        stall_obs++;
        check_eq("hold_valid", 32'(pix_valid), 1);
        check_eq("hold_data", 32'(pix_data), 32'(prev_data));
      end
      prev_stall = pix_valid && !pix_ready;
      prev_data  = pix_data;
      if (rom_en) begin
        if (first_rom_cyc < 0) first_rom_cyc = cyc;
        check_eq("rom_addr", 32'(rom_addr), 32'(n_iss));
      end
      outst = n_iss + (rom_en ? 1 : 0) - n_pop - (hs ? 1 : 0);
      if (outst > max_out) max_out = outst;
      if (rom_en) n_iss++;
      if (pix_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (hs) begin
        row = n_pop / IMG_W;
        col = n_pop % IMG_W;
        win = (row >= K_R-1) && (col >= K_S-1);
        if (exp_q.size() == 0) check_eq("extra_pixel", 32'(n_pop), 32'(N));
        else check_eq("pix_data", 32'(pix_data), 32'(exp_q.pop_front()));
        check_eq("pix_eol",   32'(pix_eol),   32'(col == IMG_W-1));
        check_eq("pix_last",  32'(pix_last),  32'(n_pop == N-1));
        check_eq("win_valid", 32'(win_valid), 32'(win));
        check_eq("out_row",   32'(out_row),   win ? 32'(row-(K_R-1)) : 0);
        check_eq("out_col",   32'(out_col),   win ? 32'(col-(K_S-1)) : 0);
        if (win_valid) begin
          win_cnt++;
          if (first_win_idx < 0) first_win_idx = n_pop;
          last_win_idx = n_pop;
        end
        if (pix_eol)  eol_cnt++;
        if (pix_last) last_cnt++;
        last_hs_cyc = cyc;
        n_pop++;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  // ---------------- driver tasks ----------------
  int start_cyc;

  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    start_cyc = cyc;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Runs one full frame and checks it against the reference model.
  task automatic run_frame(input int mode, input bit extra_start);
    bit did_extra = 0;
    bit timed_out = 1;
    rdy_mode = mode;
    stall_left = 10;
    clear_stats();
    load_image();
    pulse_start();
    for (int i = 0; i < 20000; i++) begin
      @(posedge clk);
      if (done_cnt > 0) begin
        timed_out = 0;
        break;
      end
      #1;
      start = extra_start && !did_extra && (n_pop >= 100);
      if (start) did_extra = 1;
    end
    start = 1'b0;
    check_eq("frame_timeout", 32'(timed_out), 0);
    @(negedge clk);
    check_eq("busy_after", 32'(busy), 0);
    check_eq("done_after", 32'(done), 0);
    check_eq("pix_count", 32'(n_pop), 32'(N));
    check_eq("exp_left", 32'(exp_q.size()), 0);
    check_eq("win_count", 32'(win_cnt), 32'(N_WIN));
    check_eq("eol_count", 32'(eol_cnt), 32'(IMG_H));
    check_eq("last_count", 32'(last_cnt), 1);
    check_eq("done_count", 32'(done_cnt), 1);
    check_eq("done_latency", 32'(done_cyc), 32'(last_hs_cyc + 1));
    check_eq("first_rom", 32'(first_rom_cyc), 32'(start_cyc + 1));
    check_eq("first_valid", 32'(first_valid_cyc), 32'(start_cyc + 3));
    check_eq("first_win_idx", 32'(first_win_idx), 32'((K_R-1)*IMG_W + (K_S-1)));
    check_eq("last_win_idx", 32'(last_win_idx), 32'(N-1));
    check_eq("max_outstanding", 32'(max_out <= 2), 1);
    if (mode == 0) check_eq("stream_len", 32'(last_hs_cyc - first_valid_cyc), 32'(N-1));
    if (mode == 1) check_eq("stall_cycles", 32'(stall_obs), 10);
    if (extra_start) check_eq("extra_start_sent", 32'(did_extra), 1);
  endtask

  // Starts a frame and returns once `count` pixels have transferred.
  task automatic run_until(input int count);
    bit reached = 0;
    rdy_mode = 0;
    clear_stats();
    load_image();
    pulse_start();
    for (int i = 0; i < 5000; i++) begin
      @(posedge clk);
      if (n_pop >= count) begin
        reached = 1;
        break;
      end
    end
    check_eq("reach_pixel", 32'(reached), 1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    clear_stats();
    #2;
    check_all_zero("reset");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // abort while idle: nothing may happen
    @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    check_eq("idle_abort_busy", 32'(busy), 0);

    run_frame(0, 0);   // steady stream at one pixel per cycle
    run_frame(1, 0);   // 10-cycle stall mid-row
    run_frame(2, 0);   // random back-pressure

    // abort at pixel 300, with start raised in the same cycle
    run_until(300);
    #1;
    abort = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    start = 1'b0;
    check_eq("abort_valid", 32'(pix_valid), 0);
    check_eq("abort_busy", 32'(busy), 0);
    check_eq("abort_rom_en", 32'(rom_en), 0);
    repeat (5) @(posedge clk);
    #1;
    check_eq("abort_no_done", 32'(done_cnt), 0);
    check_eq("abort_idle", 32'(busy), 0);
    run_frame(0, 0);   // replays from address 0

    // start while busy is ignored
    run_frame(0, 1);

    // reset mid-frame: outputs clear before the next clock edge
    run_until(200);
    #3 rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    run_frame(2, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
    $fatal(1, "global timeout");
  end

endmodule
